omsp_spm_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the SPM control block. It turns a single protect/unprotect request from the execution unit into the `update_spm`/`enable_spm` strobe, then streams a 128-bit module key into the control block as eight 16-bit `write_key` words. It also reports completion and success back to the execution unit, and aborts key loading when the control block flags a violation.

---
 rtl/omsp_spm_cmd_seq_pkg.sv | 16 +
 rtl/omsp_spm_cmd_seq.sv | 162 ++++++++++++++++
 tb/tb_omsp_spm_cmd_seq.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/omsp_spm_cmd_seq_pkg.sv
// Shared constants and state encoding for the SPM command sequencer.
package omsp_spm_cmd_seq_pkg;

    localparam int unsigned SPM_NB_KEY_WORDS   = 8;
    localparam int unsigned SPM_KEY_WORD_W     = 16;
    localparam int unsigned SPM_TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StUpdate = 3'd1,
        StKey    = 3'd2,
        StWrite  = 3'd3,
        StFin    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/omsp_spm_cmd_seq.sv
// Sequences protect/unprotect requests into SPM control strobes and streams the module key.
// Optional key-source idle timeout is enabled by defining SPM_KEY_TIMEOUT_EN.
module omsp_spm_cmd_seq
    import omsp_spm_cmd_seq_pkg::*;
#(
    parameter int unsigned NB_KEY_WORDS   = SPM_NB_KEY_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = SPM_TIMEOUT_CYCLES
) (
    input  logic                      mclk,
    input  logic                      puc_rst,
    input  logic                      start,
    input  logic                      op,
    output logic                      busy,
    input  logic                      key_word_valid,
    input  logic [SPM_KEY_WORD_W-1:0] key_word,
    output logic                      key_word_ready,
    input  logic                      violation,
    output logic                      update_spm,
    output logic                      enable_spm,
    output logic                      write_key,
    output logic [SPM_KEY_WORD_W-1:0] key_in,
    output logic                      done,
    output logic                      result_ok,
    output logic                      timeout
);

    localparam int unsigned CNT_W = $clog2(NB_KEY_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NB_KEY_WORDS - 1);

    if (NB_KEY_WORDS < 2 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_params
        $error("omsp_spm_cmd_seq: unsupported NB_KEY_WORDS or TIMEOUT_CYCLES");
    end

    seq_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SPM_KEY_WORD_W-1:0] key_in_q;
    logic                      op_q;
    logic                      armed_q;
    logic                      busy_q, update_q, write_q, done_q, ok_q;
    logic                      fin_ok;
    logic                      handshake;
    logic                      accept;

`ifdef SPM_KEY_TIMEOUT_EN
    logic [7:0] idle_q;
    logic       idle_expired;
    logic       fin_timeout;
    logic       timeout_q;
`endif

    assign handshake = (state_q == StKey) && key_word_valid;
    // armed_q masks a start coinciding with the first cycle after reset release
    assign accept    = (state_q == StIdle) && start && armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_ok  = 1'b0;
`ifdef SPM_KEY_TIMEOUT_EN
        fin_timeout = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StUpdate;
            end
            StUpdate: begin
                if (violation) begin
                    state_d = StFin;
                end else if (!op_q) begin
                    state_d = StFin;
                    fin_ok  = 1'b1;
                end else begin
                    state_d = StKey;
                    cnt_d   = '0;
                end
            end
            StKey: begin
                if (handshake) begin
                    state_d = StWrite;
                end
`ifdef SPM_KEY_TIMEOUT_EN
                else if (idle_expired) begin
                    state_d     = StFin;
                    fin_timeout = 1'b1;
                end
`endif
            end
            StWrite: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = StFin;
                    fin_ok  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = StKey;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they denote
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            key_in_q <= '0;
            op_q     <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            update_q <= 1'b0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= 1'b1;
            if (accept) op_q <= op;
            if (handshake) key_in_q <= key_word;
            busy_q   <= (state_d != StIdle);
            update_q <= (state_d == StUpdate);
            write_q  <= (state_d == StWrite);
            done_q   <= (state_d == StFin);
            if (state_d == StFin) ok_q <= fin_ok;
        end
    end

`ifdef SPM_KEY_TIMEOUT_EN
    assign idle_expired = (idle_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != StKey || handshake) idle_q <= '0;
            else                               idle_q <= idle_q + 1'b1;
            if (state_d == StFin) timeout_q <= fin_timeout;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy           = busy_q;
    assign key_word_ready = (state_q == StKey);
    assign update_spm     = update_q;
    assign enable_spm     = op_q;
    assign write_key      = write_q;
    assign key_in         = key_in_q;
    assign done           = done_q;
    assign result_ok      = ok_q;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Directed bench for omsp_spm_cmd_seq: cycle table plus multi-cycle load sequences.
module tb_omsp_spm_cmd_seq;
    import omsp_spm_cmd_seq_pkg::*;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        key_word_valid = 1'b0;
    logic [15:0] key_word = 16'h0;
    logic        violation = 1'b0;
    logic        busy, key_word_ready, update_spm, enable_spm, write_key;
    logic        done, result_ok, timeout;
    logic [15:0] key_in;

    omsp_spm_cmd_seq dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .start          (start),
        .op             (op),
        .busy           (busy),
        .key_word_valid (key_word_valid),
        .key_word       (key_word),
        .key_word_ready (key_word_ready),
        .violation      (violation),
        .update_spm     (update_spm),
        .enable_spm     (enable_spm),
        .write_key      (write_key),
        .key_in         (key_in),
        .done           (done),
        .result_ok      (result_ok),
        .timeout        (timeout)
    );

    always #5 mclk = ~mclk;

    // expected: {busy, update, enable, write, done, ok, timeout, ready, key_in}
    typedef struct {
        logic        st;
        logic        op;
        logic        vld;
        logic [15:0] wd;
        logic        vio;
        logic [23:0] exp;
    } vec_t;

    localparam logic [127:0] FULL_KEY = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    vec_t        tbl[29];
    logic [15:0] words[8];
    int          n_vec = 0;
    int          n_miss = 0;

    // Control-block model: first word ends up in the most significant slot
    logic [127:0] key_model = '0;
    int           done_cnt = 0;
    logic         last_ok = 1'b0;
    logic         last_to = 1'b0;
    logic [15:0]  wr_log[$];

    always @(negedge mclk) begin
        if (puc_rst) begin
            key_model <= '0;
        end else begin
            if (write_key) begin
                key_model <= {key_model[111:0], key_in};
                wr_log.push_back(key_in);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                last_ok  <= result_ok;
                last_to  <= timeout;
            end
        end
    end

    function automatic vec_t mk(input logic st, input logic opv, input logic vld,
                                input logic [15:0] wd, input logic vio,
                                input logic e_busy, input logic e_upd, input logic e_en,
                                input logic e_wr, input logic [15:0] e_key,
                                input logic e_done, input logic e_ok, input logic e_rdy);
        vec_t v;
        v.st  = st;
        v.op  = opv;
        v.vld = vld;
        v.wd  = wd;
        v.vio = vio;
        v.exp = {e_busy, e_upd, e_en, e_wr, e_done, e_ok, 1'b0, e_rdy, e_key};
        return v;
    endfunction

    function automatic logic [23:0] outs();
        return {busy, update_spm, enable_spm, write_key, done, result_ok, timeout,
                key_word_ready, key_in};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // One protect load; gap_len idle-valid cycles after each handshake, nwords words offered
    task automatic protect_load(input int gap_len, input bit extra, input int nwords,
                                output int done_cyc, output int last_hs);
        int wi;
        int gap;
        int c;
        int d0;
        bit hs;
        wi = 0;
        gap = 0;
        d0 = done_cnt;
        done_cyc = -1;
        last_hs = -1;
        @(posedge mclk); #1;
        start = 1'b1;
        op = 1'b1;
        key_word_valid = 1'b0;
        for (c = 0; c < 400 && done_cnt == d0; c++) begin
            @(negedge mclk);
            hs = key_word_valid && key_word_ready;
            @(posedge mclk); #1;
            start = extra && (c == 2 || c == 9 || c == 25);
            op = 1'b0;
            if (hs) begin
                wi++;
                gap = gap_len;
                last_hs = c;
            end
            if (gap > 0) begin
                gap--;
                key_word_valid = 1'b0;
            end else if (wi < nwords) begin
                key_word_valid = 1'b1;
                key_word = words[wi];
            end else begin
                key_word_valid = 1'b0;
            end
        end
        start = 1'b0;
        key_word_valid = 1'b0;
        if (done_cnt != d0) done_cyc = c - 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, wanted finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        int dc;
        int lh;
        int k;

        for (int i = 0; i < 8; i++) words[i] = 16'(16'h1111 * (i + 1));

        // Unprotect, then protect with violation, then protect with a source always valid
        tbl[0] = mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        tbl[1] = mk(1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        tbl[2] = mk(0, 0, 0, 16'h0, 0, 1, 1, 0, 0, 16'h0, 0, 0, 0);
        tbl[3] = mk(0, 0, 0, 16'h0, 0, 1, 0, 0, 0, 16'h0, 1, 1, 0);
        tbl[4] = mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 0);
        tbl[5] = mk(1, 1, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 0);
        tbl[6] = mk(0, 0, 0, 16'h0, 1, 1, 1, 1, 0, 16'h0, 0, 1, 0);
        tbl[7] = mk(0, 0, 0, 16'h0, 0, 1, 0, 1, 0, 16'h0, 1, 0, 0);
        tbl[8] = mk(0, 0, 0, 16'h0, 0, 0, 0, 1, 0, 16'h0, 0, 0, 0);
        tbl[9] = mk(1, 1, 0, 16'h0, 0, 0, 0, 1, 0, 16'h0, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, words[0], 0, 1, 1, 1, 0, 16'h0, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            tbl[11 + 2 * j] = mk(0, 0, 1, words[j], 0, 1, 0, 1, 0,
                                 (j == 0) ? 16'h0 : words[(j == 0) ? 0 : j - 1], 0, 0, 1);
            tbl[12 + 2 * j] = mk(0, 0, (j < 7), (j < 7) ? words[(j < 7) ? j + 1 : 0] : 16'h0,
                                 0, 1, 0, 1, 1, words[j], 0, 0, 0);
        end
        tbl[27] = mk(0, 0, 0, 16'h0, 0, 1, 0, 1, 0, words[7], 1, 1, 0);
        tbl[28] = mk(0, 0, 0, 16'h0, 0, 0, 0, 1, 0, words[7], 0, 1, 0);

        repeat (3) @(posedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(posedge mclk); #1;
            start = tbl[i].st;
            op = tbl[i].op;
            key_word_valid = tbl[i].vld;
            key_word = tbl[i].wd;
            violation = tbl[i].vio;
            @(negedge mclk);
            check($sformatf("row%0d", i), 128'(outs()), 128'(tbl[i].exp));
        end
        #1;
        check("table_key_out", key_model, FULL_KEY);

        // Gappy source and stray start pulses while busy
        n0 = wr_log.size();
        d0 = done_cnt;
        protect_load(3, 1'b1, 8, dc, lh);
        check("gap_done_count", 128'(done_cnt - d0), 128'd1);
        check("gap_writes", 128'(wr_log.size() - n0), 128'd8);
        for (int j = 0; j < 8; j++)
            check($sformatf("gap_word%0d", j), 128'(wr_log[n0 + j]), 128'(words[j]));
        check("gap_ok", 128'(last_ok), 128'd1);
        check("gap_key_out", key_model, FULL_KEY);
        repeat (15) @(posedge mclk);
        #1;
        check("gap_no_requeue", 128'(done_cnt - d0), 128'd1);
        check("gap_idle_after", 128'(busy), 128'd0);

        // Reset after the fourth key word write
        n0 = wr_log.size();
        d0 = done_cnt;
        @(posedge mclk); #1;
        start = 1'b1;
        op = 1'b1;
        key_word_valid = 1'b1;
        key_word = words[0];
        for (int c = 0; c < 60 && (wr_log.size() - n0) < 4; c++) begin
            @(posedge mclk); #1;
            start = 1'b0;
            k = wr_log.size() - n0;
            if (k > 7) k = 7;
            key_word = words[k];
        end
        check("rst_writes_before", 128'(wr_log.size() - n0), 128'd4);
        #2;
        puc_rst = 1'b1;
        #1;
        check("rst_outputs", 128'(outs()), 128'd0);
        key_word_valid = 1'b0;
        @(posedge mclk);
        @(negedge mclk);
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        check("rst_no_done", 128'(done_cnt - d0), 128'd0);
        check("rst_ctrl_cleared", key_model, 128'd0);

        n0 = wr_log.size();
        d0 = done_cnt;
        protect_load(0, 1'b0, 8, dc, lh);
        check("reload_done_cycle", 128'(dc), 128'd18);
        check("reload_done_count", 128'(done_cnt - d0), 128'd1);
        check("reload_writes", 128'(wr_log.size() - n0), 128'd8);
        for (int j = 0; j < 8; j++)
            check($sformatf("reload_word%0d", j), 128'(wr_log[n0 + j]), 128'(words[j]));
        check("reload_ok", 128'(last_ok), 128'd1);
        check("reload_timeout", 128'(last_to), 128'd0);
        check("reload_key_out", key_model, FULL_KEY);

        // Start in the cycle reset deasserts must be dropped
        d0 = done_cnt;
        @(posedge mclk); #1;
        puc_rst = 1'b1;
        start = 1'b1;
        op = 1'b0;
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        @(posedge mclk); #1;
        start = 1'b0;
        repeat (4) @(posedge mclk);
        #1;
        check("rel_start_busy", 128'(busy), 128'd0);
        check("rel_start_done", 128'(done_cnt - d0), 128'd0);

`ifdef SPM_KEY_TIMEOUT_EN
        n0 = wr_log.size();
        d0 = done_cnt;
        protect_load(0, 1'b0, 2, dc, lh);
        check("to_done_count", 128'(done_cnt - d0), 128'd1);
        check("to_writes", 128'(wr_log.size() - n0), 128'd2);
        check("to_ok", 128'(last_ok), 128'd0);
        check("to_flag", 128'(last_to), 128'd1);
        check("to_delay_in_range", 128'((dc - lh) >= 256 && (dc - lh) <= 260), 128'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
